// File: rtl/rv3n_stage_chn.sv
// Chain stage: holds a PNUM-slot instruction package, merges forwarding feeds,
// dispatches ready slots to FUNC_NUM units and forwards the remainder downstream.
module rv3n_stage_chn #(
  parameter int unsigned PNUM     = 4,
  parameter int unsigned FUNC_NUM = 3,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned PARA_W   = 8,
  parameter int unsigned IMM_W    = 13,
  parameter int unsigned AGE_W    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         chain_step,
  input  logic                         chain_flush,
  input  logic [PNUM-1:0]              chain_valid_in,
  input  logic [PNUM*PARA_W-1:0]       chain_para_in,
  input  logic [PNUM*IMM_W-1:0]        chain_imm_in,
  input  logic [PNUM*XLEN-1:0]         chain_pc_in,
  input  logic [PNUM*XLEN-1:0]         chain_rs0_in,
  input  logic [PNUM*XLEN-1:0]         chain_rs1_in,
  input  logic [PNUM*XLEN-1:0]         chain_rd_in,
  input  logic [PNUM*3-1:0]            chain_rdy_in,
  input  logic [PNUM-1:0]              chain_rs0_feed_vld,
  input  logic [PNUM-1:0]              chain_rs1_feed_vld,
  input  logic [PNUM-1:0]              chain_rd_feed_vld,
  input  logic [PNUM*XLEN-1:0]         chain_rs0_feed_data,
  input  logic [PNUM*XLEN-1:0]         chain_rs1_feed_data,
  input  logic [PNUM*XLEN-1:0]         chain_rd_feed_data,
  input  logic [PNUM*FUNC_NUM-1:0]     chain_authorized,
  output logic [PNUM-1:0]              chain_valid_out,
  output logic [PNUM*PARA_W-1:0]       chain_para_out,
  output logic [PNUM*IMM_W-1:0]        chain_imm_out,
  output logic [PNUM*XLEN-1:0]         chain_pc_out,
  output logic [PNUM*XLEN-1:0]         chain_rs0_out,
  output logic [PNUM*XLEN-1:0]         chain_rs1_out,
  output logic [PNUM*XLEN-1:0]         chain_rd_out,
  output logic [PNUM*3-1:0]            chain_rdy_out,
  output logic [PNUM*XLEN-1:0]         chain_rd_lookup_data,
  output logic [FUNC_NUM-1:0]          sub_calc_vld,
  output logic [FUNC_NUM*PARA_W-1:0]   sub_calc_para,
  output logic [FUNC_NUM*IMM_W-1:0]    sub_calc_imm,
  output logic [FUNC_NUM*XLEN-1:0]     sub_calc_pc,
  output logic [FUNC_NUM*XLEN-1:0]     sub_calc_operand0,
  output logic [FUNC_NUM*XLEN-1:0]     sub_calc_operand1,
  output logic [PNUM*AGE_W-1:0]        slot_age,
  output logic [$clog2(PNUM+1)-1:0]    occupancy,
  output logic                         auth_conflict
);

  localparam int unsigned OCC_W = $clog2(PNUM+1);

  logic [PNUM-1:0]        valid_q, valid_d;
  logic [PNUM*PARA_W-1:0] para_q,  para_d;
  logic [PNUM*IMM_W-1:0]  imm_q,   imm_d;
  logic [PNUM*XLEN-1:0]   pc_q,    pc_d;
  logic [PNUM*XLEN-1:0]   rs0_q,   rs0_d;
  logic [PNUM*XLEN-1:0]   rs1_q,   rs1_d;
  logic [PNUM*XLEN-1:0]   rd_q,    rd_d;
  logic [PNUM*3-1:0]      rdy_q,   rdy_d;
  logic [PNUM*AGE_W-1:0]  age_q,   age_d;
  logic                   conflict_q, conflict_d;

  logic [PNUM*XLEN-1:0]      m_rs0, m_rs1, m_rd;
  logic [PNUM*3-1:0]         m_rdy;
  logic [PNUM-1:0]           elig;
  logic [PNUM-1:0]           taken;
  logic [FUNC_NUM*PNUM-1:0]  gnt;
  logic                      conflict_now;

  always_comb begin
    m_rs0 = rs0_q | chain_rs0_feed_data;
    m_rs1 = rs1_q | chain_rs1_feed_data;
    m_rd  = rd_q  | chain_rd_feed_data;
    m_rdy = rdy_q;
    elig  = '0;
    for (int unsigned i = 0; i < PNUM; i++) begin
      m_rdy[i*3]   = rdy_q[i*3]   | chain_rs0_feed_vld[i];
      m_rdy[i*3+1] = rdy_q[i*3+1] | chain_rs1_feed_vld[i];
      m_rdy[i*3+2] = rdy_q[i*3+2] | chain_rd_feed_vld[i];
      elig[i]      = valid_q[i] & m_rdy[i*3] & m_rdy[i*3+1];
    end
  end

  // Units are served in index order; a slot claimed by a lower unit is
  // invisible to every higher unit.
  always_comb begin
    logic found;
    taken = '0;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < FUNC_NUM; j++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < PNUM; i++) begin
        if (!found && elig[i] && !taken[i] && chain_authorized[i*FUNC_NUM+j]) begin
          gnt[j*PNUM+i] = 1'b1;
          taken[i]      = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  always_comb begin
    logic seen;
    conflict_now = 1'b0;
    seen         = 1'b0;
    for (int unsigned i = 0; i < PNUM; i++) begin
      seen = 1'b0;
      for (int unsigned j = 0; j < FUNC_NUM; j++) begin
        if (elig[i] && chain_authorized[i*FUNC_NUM+j]) begin
          if (seen) conflict_now = 1'b1;
          seen = 1'b1;
        end
      end
    end
    for (int unsigned j = 0; j < FUNC_NUM; j++) begin
      seen = 1'b0;
      for (int unsigned i = 0; i < PNUM; i++) begin
        if (elig[i] && chain_authorized[i*FUNC_NUM+j]) begin
          if (seen) conflict_now = 1'b1;
          seen = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sub_calc_vld      = '0;
    sub_calc_para     = '0;
    sub_calc_imm      = '0;
    sub_calc_pc       = '0;
    sub_calc_operand0 = '0;
    sub_calc_operand1 = '0;
    for (int unsigned j = 0; j < FUNC_NUM; j++) begin
      for (int unsigned i = 0; i < PNUM; i++) begin
        if (gnt[j*PNUM+i]) begin
          sub_calc_vld[j] = 1'b1;
          sub_calc_para[j*PARA_W +: PARA_W]   = sub_calc_para[j*PARA_W +: PARA_W]   | para_q[i*PARA_W +: PARA_W];
          sub_calc_imm[j*IMM_W +: IMM_W]      = sub_calc_imm[j*IMM_W +: IMM_W]      | imm_q[i*IMM_W +: IMM_W];
          sub_calc_pc[j*XLEN +: XLEN]         = sub_calc_pc[j*XLEN +: XLEN]         | pc_q[i*XLEN +: XLEN];
          sub_calc_operand0[j*XLEN +: XLEN]   = sub_calc_operand0[j*XLEN +: XLEN]   | m_rs0[i*XLEN +: XLEN];
          sub_calc_operand1[j*XLEN +: XLEN]   = sub_calc_operand1[j*XLEN +: XLEN]   | m_rs1[i*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    chain_valid_out      = valid_q & ~taken;
    chain_para_out       = para_q;
    chain_imm_out        = imm_q;
    chain_pc_out         = pc_q;
    chain_rs0_out        = m_rs0;
    chain_rs1_out        = m_rs1;
    chain_rd_out         = m_rd;
    chain_rdy_out        = m_rdy;
    chain_rd_lookup_data = m_rd;
    slot_age             = age_q;
    auth_conflict        = conflict_q;
    occupancy            = '0;
    for (int unsigned i = 0; i < PNUM; i++) begin
      occupancy = occupancy + OCC_W'(valid_q[i]);
    end
  end

  always_comb begin
    valid_d    = valid_q;
    para_d     = para_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rs0_d      = rs0_q;
    rs1_d      = rs1_q;
    rd_d       = rd_q;
    rdy_d      = rdy_q;
    age_d      = age_q;
    conflict_d = conflict_now;
    if (chain_flush) begin
      valid_d    = '0;
      age_d      = '0;
      conflict_d = 1'b0;
    end else if (chain_step) begin
      valid_d = chain_valid_in;
      para_d  = chain_para_in;
      imm_d   = chain_imm_in;
      pc_d    = chain_pc_in;
      rs0_d   = chain_rs0_in;
      rs1_d   = chain_rs1_in;
      rd_d    = chain_rd_in;
      rdy_d   = chain_rdy_in;
      age_d   = '0;
    end else begin
      valid_d = valid_q & ~taken;
      rs0_d   = m_rs0;
      rs1_d   = m_rs1;
      rd_d    = m_rd;
      rdy_d   = m_rdy;
      for (int unsigned i = 0; i < PNUM; i++) begin
        if (!valid_d[i]) begin
          age_d[i*AGE_W +: AGE_W] = '0;
        end else if (age_q[i*AGE_W +: AGE_W] != '1) begin
          age_d[i*AGE_W +: AGE_W] = age_q[i*AGE_W +: AGE_W] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      para_q     <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs0_q      <= '0;
      rs1_q      <= '0;
      rd_q       <= '0;
      rdy_q      <= '0;
      age_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      para_q     <= para_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rs0_q      <= rs0_d;
      rs1_q      <= rs1_d;
      rd_q       <= rd_d;
      rdy_q      <= rdy_d;
      age_q      <= age_d;
      conflict_q <= conflict_d;
    end
  end

endmodule

// File: tb/tb_rv3n_stage_chn.sv
// Bench for rv3n_stage_chn: directed scenarios plus random traffic, every cycle
// compared against a slot-level behavioural model.
module tb_rv3n_stage_chn;
  localparam int P = 4, F = 3, X = 32, PW = 8, IW = 13, AW = 4, OW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            step, flush;
  logic [P-1:0]    valid_in, rs0_fv, rs1_fv, rd_fv;
  logic [P*PW-1:0] para_in;
  logic [P*IW-1:0] imm_in;
  logic [P*X-1:0]  pc_in, rs0_in, rs1_in, rd_in, rs0_fd, rs1_fd, rd_fd;
  logic [P*3-1:0]  rdy_in;
  logic [P*F-1:0]  auth;

  logic [P-1:0]    valid_out;
  logic [P*PW-1:0] para_out;
  logic [P*IW-1:0] imm_out;
  logic [P*X-1:0]  pc_out, rs0_out, rs1_out, rd_out, lookup;
  logic [P*3-1:0]  rdy_out;
  logic [F-1:0]    sc_vld;
  logic [F*PW-1:0] sc_para;
  logic [F*IW-1:0] sc_imm;
  logic [F*X-1:0]  sc_pc, sc_op0, sc_op1;
  logic [P*AW-1:0] age;
  logic [OW-1:0]   occ;
  logic            conf;

  rv3n_stage_chn #(.PNUM(P), .FUNC_NUM(F), .XLEN(X), .PARA_W(PW), .IMM_W(IW), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .chain_step(step), .chain_flush(flush),
    .chain_valid_in(valid_in), .chain_para_in(para_in), .chain_imm_in(imm_in),
    .chain_pc_in(pc_in), .chain_rs0_in(rs0_in), .chain_rs1_in(rs1_in), .chain_rd_in(rd_in),
    .chain_rdy_in(rdy_in),
    .chain_rs0_feed_vld(rs0_fv), .chain_rs1_feed_vld(rs1_fv), .chain_rd_feed_vld(rd_fv),
    .chain_rs0_feed_data(rs0_fd), .chain_rs1_feed_data(rs1_fd), .chain_rd_feed_data(rd_fd),
    .chain_authorized(auth),
    .chain_valid_out(valid_out), .chain_para_out(para_out), .chain_imm_out(imm_out),
    .chain_pc_out(pc_out), .chain_rs0_out(rs0_out), .chain_rs1_out(rs1_out), .chain_rd_out(rd_out),
    .chain_rdy_out(rdy_out), .chain_rd_lookup_data(lookup),
    .sub_calc_vld(sc_vld), .sub_calc_para(sc_para), .sub_calc_imm(sc_imm), .sub_calc_pc(sc_pc),
    .sub_calc_operand0(sc_op0), .sub_calc_operand1(sc_op1),
    .slot_age(age), .occupancy(occ), .auth_conflict(conf)
  );

  int total = 0;
  int bad   = 0;

  // model state, one entry per slot
  bit          m_v[P];
  logic [PW-1:0] m_para[P];
  logic [IW-1:0] m_imm[P];
  logic [X-1:0]  m_pc[P], m_rs0[P], m_rs1[P], m_rd[P];
  logic [2:0]    m_rdy[P];
  int            m_age[P];
  bit            m_conf;

  // model view of the current cycle
  logic [X-1:0] e_rs0[P], e_rs1[P], e_rd[P];
  logic [2:0]   e_rdy[P];
  bit           e_elig[P], e_disp[P];
  int           e_gnt[F];
  bit           e_conf;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < P; i++) begin
      m_v[i] = 0; m_para[i] = '0; m_imm[i] = '0; m_pc[i] = '0;
      m_rs0[i] = '0; m_rs1[i] = '0; m_rd[i] = '0; m_rdy[i] = '0; m_age[i] = 0;
    end
    m_conf = 0;
  endtask

  task automatic model_eval();
    int n;
    for (int i = 0; i < P; i++) begin
      e_rs0[i]  = m_rs0[i] | rs0_fd[i*X +: X];
      e_rs1[i]  = m_rs1[i] | rs1_fd[i*X +: X];
      e_rd[i]   = m_rd[i]  | rd_fd[i*X +: X];
      e_rdy[i]  = m_rdy[i] | {rd_fv[i], rs1_fv[i], rs0_fv[i]};
      e_elig[i] = m_v[i] && e_rdy[i][0] && e_rdy[i][1];
      e_disp[i] = 0;
    end
    e_conf = 0;
    for (int j = 0; j < F; j++) begin
      e_gnt[j] = -1;
      n = 0;
      for (int i = 0; i < P; i++) begin
        if (e_elig[i] && auth[i*F+j]) n++;
        if (e_gnt[j] < 0 && e_elig[i] && !e_disp[i] && auth[i*F+j]) begin
          e_gnt[j]  = i;
          e_disp[i] = 1;
        end
      end
      if (n > 1) e_conf = 1;
    end
    for (int i = 0; i < P; i++)
      if (e_elig[i] && $countones(auth[i*F +: F]) > 1) e_conf = 1;
  endtask

  task automatic check_all();
    logic [127:0] x_v, x_para, x_imm, x_pc, x_rs0, x_rs1, x_rd, x_rdy;
    logic [127:0] x_svld, x_spara, x_simm, x_spc, x_sop0, x_sop1, x_age, x_occ;
    int cnt;
    model_eval();
    {x_v, x_para, x_imm, x_pc, x_rs0, x_rs1, x_rd, x_rdy} = '0;
    {x_svld, x_spara, x_simm, x_spc, x_sop0, x_sop1, x_age} = '0;
    cnt = 0;
    for (int i = 0; i < P; i++) begin
      x_v[i] = m_v[i] && !e_disp[i];
      x_para[i*PW +: PW] = m_para[i];
      x_imm[i*IW +: IW]  = m_imm[i];
      x_pc[i*X +: X]     = m_pc[i];
      x_rs0[i*X +: X]    = e_rs0[i];
      x_rs1[i*X +: X]    = e_rs1[i];
      x_rd[i*X +: X]     = e_rd[i];
      x_rdy[i*3 +: 3]    = e_rdy[i];
      x_age[i*AW +: AW]  = AW'(m_age[i]);
      if (m_v[i]) cnt++;
    end
    for (int j = 0; j < F; j++) begin
      if (e_gnt[j] >= 0) begin
        x_svld[j] = 1'b1;
        x_spara[j*PW +: PW] = m_para[e_gnt[j]];
        x_simm[j*IW +: IW]  = m_imm[e_gnt[j]];
        x_spc[j*X +: X]     = m_pc[e_gnt[j]];
        x_sop0[j*X +: X]    = e_rs0[e_gnt[j]];
        x_sop1[j*X +: X]    = e_rs1[e_gnt[j]];
      end
    end
    x_occ = 128'(cnt);
    chk("valid_out", 128'(valid_out), x_v);
    chk("para_out",  128'(para_out),  x_para);
    chk("imm_out",   128'(imm_out),   x_imm);
    chk("pc_out",    128'(pc_out),    x_pc);
    chk("rs0_out",   128'(rs0_out),   x_rs0);
    chk("rs1_out",   128'(rs1_out),   x_rs1);
    chk("rd_out",    128'(rd_out),    x_rd);
    chk("rd_lookup", 128'(lookup),    x_rd);
    chk("rdy_out",   128'(rdy_out),   x_rdy);
    chk("sc_vld",    128'(sc_vld),    x_svld);
    chk("sc_para",   128'(sc_para),   x_spara);
    chk("sc_imm",    128'(sc_imm),    x_simm);
    chk("sc_pc",     128'(sc_pc),     x_spc);
    chk("sc_op0",    128'(sc_op0),    x_sop0);
    chk("sc_op1",    128'(sc_op1),    x_sop1);
    chk("slot_age",  128'(age),       x_age);
    chk("occupancy", 128'(occ),       x_occ);
    chk("auth_conf", 128'(conf),      128'(m_conf));
  endtask

  task automatic model_clock();
    if (flush) begin
      for (int i = 0; i < P; i++) begin m_v[i] = 0; m_age[i] = 0; end
      m_conf = 0;
    end else begin
      m_conf = e_conf;
      for (int i = 0; i < P; i++) begin
        if (step) begin
          m_v[i] = valid_in[i]; m_para[i] = para_in[i*PW +: PW]; m_imm[i] = imm_in[i*IW +: IW];
          m_pc[i] = pc_in[i*X +: X]; m_rs0[i] = rs0_in[i*X +: X]; m_rs1[i] = rs1_in[i*X +: X];
          m_rd[i] = rd_in[i*X +: X]; m_rdy[i] = rdy_in[i*3 +: 3]; m_age[i] = 0;
        end else begin
          m_v[i] = m_v[i] && !e_disp[i];
          m_rs0[i] = e_rs0[i]; m_rs1[i] = e_rs1[i]; m_rd[i] = e_rd[i]; m_rdy[i] = e_rdy[i];
          m_age[i] = m_v[i] ? ((m_age[i] < 15) ? m_age[i] + 1 : 15) : 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic clear_in();
    step = 0; flush = 0; valid_in = '0; para_in = '0; imm_in = '0; pc_in = '0;
    rs0_in = '0; rs1_in = '0; rd_in = '0; rdy_in = '0;
    rs0_fv = '0; rs1_fv = '0; rd_fv = '0; rs0_fd = '0; rs1_fd = '0; rd_fd = '0; auth = '0;
  endtask

  task automatic rand_pkg();
    valid_in = P'($urandom);
    for (int i = 0; i < P; i++) begin
      para_in[i*PW +: PW] = PW'($urandom);
      imm_in[i*IW +: IW]  = IW'($urandom);
      pc_in[i*X +: X]     = $urandom;
      rs0_in[i*X +: X]    = $urandom;
      rs1_in[i*X +: X]    = $urandom;
      rd_in[i*X +: X]     = $urandom;
    end
    rdy_in = (P*3)'($urandom);
  endtask

  initial begin
    clear_in();
    model_reset();
    rst = 1;
    #12;
    chk("reset_valid", 128'(valid_out), '0);
    chk("reset_occ",   128'(occ),       '0);
    @(posedge clk); #1;
    rst = 0;
    cyc();

    // load slot0 waiting on rs1, then feed rs1 and dispatch to unit1 that cycle
    step = 1; valid_in = 4'b0001; rdy_in[2:0] = 3'b001; auth[1] = 1'b1; rs0_in[31:0] = 32'h11;
    pc_in[31:0] = 32'h400;
    cyc();
    clear_in(); auth[1] = 1'b1; rs1_fv[0] = 1'b1; rs1_fd[31:0] = 32'h55;
    #1;
    chk("feed_sc_vld", 128'(sc_vld), 128'(3'b010));
    chk("feed_op1",    128'(sc_op1[63:32]), 128'(32'h55));
    chk("feed_occ",    128'(occ), 128'(1));
    cyc();
    clear_in();
    chk("after_disp_valid", 128'(valid_out[0]), '0);
    chk("after_disp_occ",   128'(occ), '0);
    cyc();

    // slots 1 and 3 both want unit0
    step = 1; valid_in = 4'b1010; rdy_in = 12'b011_000_011_000; auth[1*F] = 1'b1; auth[3*F] = 1'b1;
    cyc();
    step = 0; valid_in = '0; rdy_in = '0;
    cyc();
    chk("prio_age3", 128'(age[15:12]), 128'(1));
    chk("prio_conf", 128'(conf), 128'(1));
    chk("prio_occ",  128'(occ), 128'(1));
    clear_in();
    cyc();

    // slot2 authorised for units 0 and 2; slot3 for unit2
    step = 1; valid_in = 4'b1100; rdy_in = 12'b011_011_000_000;
    auth[2*F+0] = 1'b1; auth[2*F+2] = 1'b1; auth[3*F+2] = 1'b1;
    pc_in[95:64] = 32'h2000; pc_in[127:96] = 32'h3000;
    cyc();
    step = 0; valid_in = '0;
    #1;
    chk("multi_vld",  128'(sc_vld), 128'(3'b101));
    chk("multi_pc2",  128'(sc_pc[95:64]), 128'(32'h3000));
    chk("multi_pc0",  128'(sc_pc[31:0]), 128'(32'h2000));
    cyc();
    step = 1; valid_in = 4'b0100; auth[3*F+2] = 1'b0;
    cyc();
    step = 0; valid_in = '0;
    #1;
    chk("multi_only", 128'(sc_vld), 128'(3'b001));
    cyc();
    clear_in();

    // unready slot ages to saturation
    step = 1; valid_in = 4'b0001;
    cyc();
    step = 0; valid_in = '0;
    for (int k = 0; k < 20; k++) cyc();
    chk("age_sat", 128'(age[3:0]), 128'(15));
    cyc();
    chk("age_hold", 128'(age[3:0]), 128'(15));

    // flush beats step
    flush = 1; step = 1; valid_in = '1; rdy_in = '1; auth = '1;
    cyc();
    clear_in();
    chk("flush_valid", 128'(valid_out), '0);
    chk("flush_age",   128'(age), '0);
    chk("flush_occ",   128'(occ), '0);
    cyc();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      clear_in();
      step  = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if (step) rand_pkg();
      rs0_fv = P'($urandom); rs1_fv = P'($urandom); rd_fv = P'($urandom);
      for (int i = 0; i < P; i++) begin
        if (rs0_fv[i]) rs0_fd[i*X +: X] = $urandom;
        if (rs1_fv[i]) rs1_fd[i*X +: X] = $urandom;
        if (rd_fv[i])  rd_fd[i*X +: X]  = $urandom;
      end
      auth = (P*F)'($urandom);
      cyc();
    end

    // asynchronous reset mid-cycle with a loaded package
    clear_in();
    step = 1; valid_in = '1; rdy_in = '1; pc_in = '1; auth = 12'h249;
    cyc();
    clear_in();
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 128'(valid_out), '0);
    chk("arst_vld",   128'(sc_vld), '0);
    chk("arst_pc",    128'(pc_out), '0);
    chk("arst_age",   128'(age), '0);
    model_reset();
    @(posedge clk); #1;
    rst = 0;
    cyc();
    chk("arst_occ", 128'(occ), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
